// File: rtl/spi_pkg.sv
// Shared types for the SPI master sequencer: FSM states and the {cpol,cpha}
// mode encoding.
package spi_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LEAD = 2'd1, SHIFT = 2'd2, TRAIL = 2'd3} state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic mode_cpol(input logic [1:0] m);
    return (m == MODE2) || (m == MODE3);
  endfunction

  function automatic logic mode_cpha(input logic [1:0] m);
    return (m == MODE1) || (m == MODE3);
  endfunction
endpackage

// File: rtl/spi_half_period_tick.sv
// SCLK half-period divider: pulses tick once every 2^spr clk cycles,
// restarting from zero whenever clr is asserted.
module spi_half_period_tick #(
  parameter int PRESCALAR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [PRESCALAR_WIDTH-1:0] spr,
  output logic                       tick
);
  localparam int CW = 2 ** PRESCALAR_WIDTH;

  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;

  assign lim  = (CW'(1) << spr) - CW'(1);
  assign tick = (cnt == lim);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/spi_master_seq.sv
// SPI master transfer sequencer: one word per handshake, all four CPOL/CPHA
// modes, MSB first, SCLK half-period of 2^spr clk cycles.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int PRESCALAR_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PRESCALAR_WIDTH-1:0] spr,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic [DATA_WIDTH-1:0]      tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [DATA_WIDTH-1:0]      rx_data,
  output logic                       rx_valid,
  output logic                       busy,
  output logic                       ss_n,
  output logic                       sclk,
  output logic                       mosi,
  input  logic                       miso
);
  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_WIDTH - 1);

  state_t                     state;
  logic [1:0]                 cfg_mode;
  logic [PRESCALAR_WIDTH-1:0] cfg_spr;
  logic [DATA_WIDTH-1:0]      tx_sr, rx_sr;
  logic [EW-1:0]              e;
  logic                       tick, accept, cfg_cpol, cfg_cpha, lead_e;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;
  assign cfg_cpol = mode_cpol(cfg_mode);
  assign cfg_cpha = mode_cpha(cfg_mode);
  assign lead_e   = ~e[0];

  spi_half_period_tick #(.PRESCALAR_WIDTH(PRESCALAR_WIDTH)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .spr  (cfg_spr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ss_n     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cfg_mode <= '0;
      cfg_spr  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      e        <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cfg_mode <= {cpol, cpha};
          cfg_spr  <= spr;
          ss_n     <= 1'b1;
          sclk     <= cfg_cpol;
          if (accept) begin
            state <= LEAD;
            ss_n  <= 1'b0;
            sclk  <= cpol;
            e     <= '0;
            // cpha=0 presents the MSB before the first edge; cpha=1 drives it on edge 0
            tx_sr <= cpha ? tx_data : (tx_data << 1);
            if (!cpha) mosi <= tx_data[DATA_WIDTH-1];
          end
        end
        LEAD: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          sclk <= ~sclk;
          e    <= e + EW'(1);
          if (lead_e ^ cfg_cpha) begin
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
          end else if (cfg_cpha || (e != LAST_E)) begin
            mosi  <= tx_sr[DATA_WIDTH-1];
            tx_sr <= tx_sr << 1;
          end
          if (e == LAST_E) state <= TRAIL;
        end
        TRAIL: if (tick) begin
          state    <= IDLE;
          ss_n     <= 1'b1;
          rx_valid <= 1'b1;
          rx_data  <= rx_sr;
        end
        default: begin
          state <= IDLE;
          ss_n  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_seq.sv
// Directed bench for spi_master_seq: table of single transfers plus
// back-to-back, mid-transfer config change and mid-transfer reset sequences.
module tb_spi_master_seq;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] spr = '0;
  logic       cpol = 1'b0, cpha = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, ss_n, sclk, mosi, miso;
  logic [7:0] rx_data;

  logic [1:0] slv_mode = '0;   // 0: loopback, 1: tied high, 2: slave shifting slv_pat
  logic [7:0] slv_pat = '0;
  logic       slv_q = 1'b0;
  int         slv_idx = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_seq #(.DATA_WIDTH(8), .PRESCALAR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .spr(spr), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  assign miso = (slv_mode == 2'd0) ? mosi : (slv_mode == 2'd1) ? 1'b1 : slv_q;

  // Slave for mode 1: puts the next bit on miso at each rising (leading) SCLK edge
  always @(posedge sclk or posedge ss_n) begin
    if (ss_n) slv_idx = 0;
    else if (slv_idx < 8) begin
      slv_q   = slv_pat[7 - slv_idx];
      slv_idx = slv_idx + 1;
    end
  end

  typedef struct {
    logic [1:0] mode;
    logic [2:0] spr;
    logic [7:0] tx;
    logic [1:0] slv;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    int         exp_low;
    int         exp_lvl;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input int chg_edge, input string nm);
    int   low, tog, run, lmin, lmax, bad, extra;
    logic sq, mq, sp, done, run_on, chg_done;
    @(negedge clk);
    cpol = v.mode[1]; cpha = v.mode[0]; spr = v.spr; tx_data = v.tx;
    slv_mode = v.slv; slv_pat = v.pat;
    repeat (2) @(negedge clk);
    chk({nm, " idle_sclk"}, sclk, v.mode[1]);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk({nm, " accept_ss_low"}, ss_n, 1'b0);
    chk({nm, " busy"}, busy, 1'b1);
    low = 0; tog = 0; run = 0; lmin = 1000; lmax = 0; bad = 0; extra = 0;
    sq = sclk; mq = mosi; sp = ss_n; done = 1'b0; run_on = 1'b0; chg_done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (!ss_n) low++;
      if (mosi != mq && !(sclk != sq && sclk != v.mode[1])) bad++;
      if (sclk != sq) begin
        tog++;
        if (run_on) begin
          if (run < lmin) lmin = run;
          if (run > lmax) lmax = run;
        end
        run_on = 1'b1;
        run = 1;
      end else run++;
      if (chg_edge >= 0 && !chg_done && tog == chg_edge) begin
        spr = 3'd3; cpol = ~cpol; chg_done = 1'b1;
      end
      if (rx_valid) begin
        done = 1'b1;
        chk({nm, " rx_data"}, rx_data, v.exp_rx);
        chk({nm, " ss_rise_at_rx_valid"}, {sp, ss_n}, 2'b01);
        chk({nm, " end_sclk_idle"}, sclk, v.mode[1]);
        chk({nm, " tx_ready_at_rx_valid"}, tx_ready, 1'b1);
      end
      sq = sclk; mq = mosi; sp = ss_n;
    end
    chk({nm, " completed"}, done, 1'b1);
    chk({nm, " ss_low_cycles"}, low, v.exp_low);
    chk({nm, " sclk_toggles"}, tog, 16);
    chk({nm, " sclk_level_min"}, lmin, v.exp_lvl);
    chk({nm, " sclk_level_max"}, lmax, v.exp_lvl);
    if (v.mode[0]) chk({nm, " mosi_lead_only"}, bad, 0);
    repeat (3) begin
      @(negedge clk);
      if (rx_valid) extra++;
    end
    chk({nm, " single_rx_valid"}, extra, 0);
  endtask

  initial begin
    vec_t v;
    logic got;
    int   tog;
    logic sq;

    tbl[0] = '{MODE0, 3'd0, 8'hA5, 2'd0, 8'h00, 8'hA5, 18, 1};
    tbl[1] = '{MODE3, 3'd2, 8'h3C, 2'd1, 8'h00, 8'hFF, 72, 4};
    tbl[2] = '{MODE1, 3'd1, 8'hE7, 2'd2, 8'h5A, 8'h5A, 36, 2};
    tbl[3] = '{MODE2, 3'd0, 8'h96, 2'd0, 8'h00, 8'h96, 18, 1};
    tbl[4] = '{MODE1, 3'd0, 8'h69, 2'd0, 8'h00, 8'h69, 18, 1};
    tbl[5] = '{MODE3, 3'd1, 8'hC5, 2'd0, 8'h00, 8'hC5, 36, 2};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst ss_n", ss_n, 1'b1);
    chk("rst sclk", sclk, 1'b0);
    chk("rst mosi", mosi, 1'b0);
    chk("rst rx_data", rx_data, 8'h00);
    chk("rst rx_valid", rx_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst tx_ready", tx_ready, 1'b1);

    foreach (tbl[i]) run_xfer(tbl[i], -1, $sformatf("vec%0d", i));

    // back-to-back with tx_valid held
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; spr = 3'd0; slv_mode = 2'd0;
    repeat (2) @(negedge clk);
    tx_data = 8'h01; tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h02;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    chk("b2b first_done", got, 1'b1);
    chk("b2b rx1", rx_data, 8'h01);
    chk("b2b ss_high_at_rx", ss_n, 1'b1);
    chk("b2b ready_at_rx", tx_ready, 1'b1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("b2b ss_gap_one_cycle", ss_n, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    chk("b2b second_done", got, 1'b1);
    chk("b2b rx2", rx_data, 8'h02);

    // config changed at edge 5 is ignored until the next transfer
    v = '{MODE0, 3'd0, 8'h5C, 2'd0, 8'h00, 8'h5C, 18, 1};
    run_xfer(v, 5, "midcfg");
    v = '{MODE2, 3'd3, 8'hB1, 2'd0, 8'h00, 8'hB1, 144, 8};
    run_xfer(v, -1, "newcfg");

    // reset at edge 7 aborts the transfer
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; spr = 3'd0; slv_mode = 2'd0; tx_data = 8'h77;
    repeat (2) @(negedge clk);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tog = 0; sq = sclk;
    for (int c = 0; c < 200 && tog < 7; c++) begin
      @(negedge clk);
      if (sclk != sq) tog++;
      sq = sclk;
    end
    chk("abort reached_edge7", tog, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ss_n", ss_n, 1'b1);
    chk("abort sclk", sclk, 1'b0);
    chk("abort tx_ready", tx_ready, 1'b1);
    chk("abort rx_valid", rx_valid, 1'b0);
    rst = 1'b0;
    got = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rx_valid) got = 1'b1;
    end
    chk("abort no_rx_valid", got, 1'b0);
    v = '{MODE0, 3'd0, 8'hC3, 2'd0, 8'h00, 8'hC3, 18, 1};
    run_xfer(v, -1, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
SPI master transfer sequencer for the SPI block. It accepts one DATA_WIDTH-bit word per valid/ready handshake and drives ss_n, sclk and mosi for all four CPOL/CPHA modes. It samples miso and returns the received word with a one-cycle valid pulse. The SCLK half-period is 2^spr clk cycles, the same prescaling law as the baud-rate generator, produced by an internal tick sub-module so the divider restarts at every transfer.

Parameters:
DATA_WIDTH, 8, bits per transfer (MSB first)
PRESCALAR_WIDTH, 3, width of spr; half-period range is 2^0 to 2^(2^PRESCALAR_WIDTH-1) clk cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
spr  in  PRESCALAR_WIDTH  prescaler select; half-period = 2^spr clk cycles
cpol  in  1  SCLK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
tx_data  in  DATA_WIDTH  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  block can accept a word (high only in IDLE)
rx_data  out  DATA_WIDTH  last received word, held until the next completion
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  transfer in progress (state != IDLE)
ss_n  out  1  slave select, active low
sclk  out  1  SPI clock
mosi  out  1  master out
miso  in  1  master in

Behaviour:
- Reset (rst high at a clk edge): state IDLE, ss_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, busy=0, latched cfg=0. A reset mid-transfer aborts it: ss_n=1 next cycle, no rx_valid.
- tx_ready = (state==IDLE), registered-state based, so it is 1 from the first cycle after reset.
- In IDLE, cfg_cpol/cpha/spr are loaded from the inputs every cycle and sclk = cfg_cpol. Config is frozen from accept to completion; input changes mid-transfer are ignored.
- Accept on tx_valid && tx_ready: load shift register with tx_data, clear the divider, clear edge count, go to LEAD.
- Half-period tick: one-cycle pulse after every 2^spr cycles, counted from divider clear. With spr=0 the tick is high every cycle.
- LEAD: ss_n=0, sclk=cfg_cpol. mosi = tx MSB when cpha=0; mosi unchanged when cpha=1. Next tick goes to SHIFT.
- SHIFT: each tick toggles sclk and increments edge count e (0 to 2*DATA_WIDTH-1). Even e is a leading edge, odd e is a trailing edge.
  - cpha=0: sample miso into the rx shift LSB on even e; shift mosi to the next bit on odd e, except the final edge.
  - cpha=1: drive the next mosi bit (first bit at e=0) on even e; sample on odd e.
  - After edge 2*DATA_WIDTH-1, sclk is back at cfg_cpol; go to TRAIL.
- TRAIL: ss_n=0, sclk idle, one half-period, then IDLE.
- Entry to IDLE: ss_n=1 and rx_valid=1 for exactly that cycle; rx_data = received word. tx_ready is already 1 in that cycle, so a new accept there is legal (back-to-back). ss_n is guaranteed high for at least 1 cycle between transfers.
- Timing:
  - ss_n low duration = (2*DATA_WIDTH+2)*2^spr cycles, e.g. 18 cycles at spr=0, DATA_WIDTH=8.
  - rx_valid occurs 1 cycle after the last ss_n-low cycle.
  - Accept to ss_n low is 1 cycle.
- miso is sampled at the same clk edge at which the sclk register toggles.
- Unused state encodings return to IDLE.

Decomposition:
- Package spi_pkg: state enum {IDLE, LEAD, SHIFT, TRAIL}; constants for mode encoding {cpol,cpha} (MODE0 to MODE3).
- Sub-module spi_half_period_tick: inputs clk, rst, clr, spr; output tick.
  - Counter width 2^PRESCALAR_WIDTH.
  - tick when counter == 2^spr-1, after which the counter wraps to 0.
  - clr forces the counter to 0.

Test Plan:
- Mode 0, spr=0, tx_data=0xA5, miso looped to mosi -> ss_n low 18 cycles; 16 sclk toggles idling at 0; rx_data=0xA5; one rx_valid pulse.
- Mode 3, spr=2, tx_data=0x3C, miso tied 1 -> sclk idles at 1; each sclk level lasts 4 cycles; ss_n low 72 cycles; rx_data=0xFF.
- Mode 1, spr=1, slave model shifting out 0x5A on leading edges -> rx_data=0x5A; mosi changes only on leading edges.
- Back-to-back: tx_valid held with 0x01 then 0x02, spr=0 -> second accept on the rx_valid cycle; ss_n high exactly 1 cycle between transfers; rx words match in order.
- Mid-transfer changes: spr 0->3 and cpol toggled at edge 5 -> transfer completes with the original timing and polarity; new config applies to the next transfer.
- rst pulsed at edge 7 of a mode-0 transfer -> next cycle ss_n=1, sclk=0, tx_ready=1, no rx_valid; a following transfer of 0xC3 completes correctly.
